// File: rtl/spi_ram_arbiter_pkg.sv
// Shared definitions for the SPI/host RAM command arbiter: command opcodes,
// arbiter state encoding and datapath widths.
package spi_ram_arbiter_pkg;

  localparam int CMD_W  = 10;
  localparam int DATA_W = 8;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'b00,
    ARB_LOCK_WR = 2'b01,
    ARB_LOCK_RD = 2'b10,
    ARB_WAIT_RD = 2'b11
  } arb_state_e;

  // Opcode lives in the two top bits of every RAM command word.
  function automatic logic [1:0] cmd_op(input logic [CMD_W-1:0] word);
    return word[CMD_W-1 -: 2];
  endfunction

endpackage

// File: rtl/spi_ram_arbiter_rr_pick.sv
// Two-way round-robin grant: a lone valid wins, a tie goes to the requester
// that was not granted last.
module spi_ram_rr_pick (
  input  logic [1:0] valid,
  input  logic       rr_last,
  output logic [1:0] grant
);

  // One-hot grant from the valid pair and the last-served index.
  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = rr_last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/spi_ram_arbiter.sv
// Arbitrates the single-port RAM command channel between the SPI slave and a host
// port, locking across address/data pairs. Optional lock timeout: SPI_RAM_ARB_TIMEOUT_EN.
module spi_ram_arbiter
  import spi_ram_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TO_W           = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [CMD_W-1:0]  req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [CMD_W-1:0]  req1_data,
  output logic              req1_ready,
  output logic              ram_rx_valid,
  output logic [CMD_W-1:0]  ram_din,
  input  logic              ram_tx_valid,
  input  logic [DATA_W-1:0] ram_dout,
  output logic [1:0]        rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              lock_timeout
);

  arb_state_e       state;
  logic             owner;
  logic             rr_last;
  logic [1:0]       valid;
  logic [1:0]       pick_grant;
  logic [1:0]       ready;
  logic [1:0]       owner_mask;
  logic             xfer;
  logic             xfer_idx;
  logic [CMD_W-1:0] xfer_word;
  logic [1:0]       xfer_op;

  assign valid      = {req1_valid, req0_valid};
  assign owner_mask = owner ? 2'b10 : 2'b01;

  spi_ram_rr_pick u_pick (
    .valid   (valid),
    .rr_last (rr_last),
    .grant   (pick_grant)
  );

  // Ready is only raised for a requester whose command will actually transfer.
  always_comb begin
    ready = 2'b00;
    case (state)
      ARB_IDLE:    ready = pick_grant;
      ARB_LOCK_WR: ready = valid & owner_mask;
      ARB_LOCK_RD: ready = valid & owner_mask;
      ARB_WAIT_RD: ready = 2'b00;
      default:     ready = 2'b00;
    endcase
  end

  assign req0_ready = ready[0];
  assign req1_ready = ready[1];
  assign xfer       = |ready;
  assign xfer_idx   = ready[1];
  assign xfer_word  = xfer_idx ? req1_data : req0_data;
  assign xfer_op    = cmd_op(xfer_word);

`ifdef SPI_RAM_ARB_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt;
  logic [TO_W-1:0] to_cnt_next;
  logic            locked;
  logic            rsp_now;
  logic            to_fire;

  assign locked      = (state != ARB_IDLE);
  assign rsp_now     = (state == ARB_WAIT_RD) && ram_tx_valid;
  assign to_cnt_next = to_cnt + {{(TO_W-1){1'b0}}, 1'b1};
  // A live transfer or a RAM response always beats the idle-lock timeout.
  assign to_fire     = locked && !xfer && !rsp_now &&
                       (to_cnt_next == TO_W'(TIMEOUT_CYCLES));

  // Idle-lock counter and the forced-release pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt       <= {TO_W{1'b0}};
      lock_timeout <= 1'b0;
    end else begin
      lock_timeout <= to_fire;
      if (xfer || !locked || to_fire) begin
        to_cnt <= {TO_W{1'b0}};
      end else begin
        to_cnt <= to_cnt_next;
      end
    end
  end
`else
  logic to_fire;
  assign to_fire      = 1'b0;
  assign lock_timeout = 1'b0;
`endif

  // Arbiter FSM plus registered RAM command and response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ARB_IDLE;
      owner        <= 1'b0;
      rr_last      <= 1'b1;
      ram_rx_valid <= 1'b0;
      ram_din      <= {CMD_W{1'b0}};
      rsp_valid    <= 2'b00;
      rsp_data     <= {DATA_W{1'b0}};
    end else begin
      ram_rx_valid <= xfer;
      rsp_valid    <= 2'b00;
      if (xfer) begin
        ram_din <= xfer_word;
        rr_last <= xfer_idx;
      end
      if (to_fire) begin
        state   <= ARB_IDLE;
        rr_last <= owner;
      end else begin
        case (state)
          ARB_IDLE: begin
            if (xfer) begin
              case (xfer_op)
                CMD_WR_ADDR: begin state <= ARB_LOCK_WR; owner <= xfer_idx; end
                CMD_RD_ADDR: begin state <= ARB_LOCK_RD; owner <= xfer_idx; end
                CMD_RD_DATA: begin state <= ARB_WAIT_RD; owner <= xfer_idx; end
                default:     state <= ARB_IDLE;
              endcase
            end
          end
          ARB_LOCK_WR: begin
            if (xfer) begin
              case (xfer_op)
                CMD_WR_ADDR: state <= ARB_LOCK_WR;
                CMD_WR_DATA: state <= ARB_IDLE;
                CMD_RD_ADDR: state <= ARB_LOCK_RD;
                CMD_RD_DATA: state <= ARB_WAIT_RD;
                default:     state <= ARB_IDLE;
              endcase
            end
          end
          ARB_LOCK_RD: begin
            if (xfer) begin
              case (xfer_op)
                CMD_WR_ADDR: state <= ARB_LOCK_WR;
                CMD_WR_DATA: state <= ARB_IDLE;
                CMD_RD_ADDR: state <= ARB_LOCK_RD;
                CMD_RD_DATA: state <= ARB_WAIT_RD;
                default:     state <= ARB_IDLE;
              endcase
            end
          end
          ARB_WAIT_RD: begin
            if (ram_tx_valid) begin
              rsp_valid <= owner_mask;
              rsp_data  <= ram_dout;
              state     <= ARB_IDLE;
            end
          end
          default: state <= ARB_IDLE;
        endcase
      end
    end
  end

endmodule
